// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared INVTLB op codes, page sizes and engine state encoding
// Purpose: constants and types shared by the TLB invalidation engine and its match predicate.
// Ports: none (package).
package tlb_pkg;

  localparam logic [4:0] INV_ALL0     = 5'd0;
  localparam logic [4:0] INV_ALL1     = 5'd1;
  localparam logic [4:0] INV_G        = 5'd2;
  localparam logic [4:0] INV_NG       = 5'd3;
  localparam logic [4:0] INV_ASID     = 5'd4;
  localparam logic [4:0] INV_ASID_VA  = 5'd5;
  localparam logic [4:0] INV_GASID_VA = 5'd6;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } inv_state_e;

endpackage

// File: rtl/tlb_inv_engine_if.sv
// rtl/tlb_inv_engine_if.sv - request/completion and TLB access signals of the invalidation engine
// Purpose: bundles the INVTLB request handshake, completion status, TLB entry read port
//          and invalidate write port.
// Ports (slave = engine side):
//   in : req_valid, req_op, req_asid, req_vppn, rd_e, rd_g, rd_asid, rd_vppn, rd_ps
//   out: req_ready, busy, rd_idx, inv_we, inv_idx, done, done_err
interface tlb_inv_engine_if #(
  parameter int IDX_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_op;
  logic [9:0]       req_asid;
  logic [18:0]      req_vppn;
  logic             busy;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_e;
  logic             rd_g;
  logic [9:0]       rd_asid;
  logic [18:0]      rd_vppn;
  logic [5:0]       rd_ps;
  logic             inv_we;
  logic [IDX_W-1:0] inv_idx;
  logic             done;
  logic             done_err;

  modport slave (
    input  req_valid, req_op, req_asid, req_vppn,
    input  rd_e, rd_g, rd_asid, rd_vppn, rd_ps,
    output req_ready, busy, rd_idx, inv_we, inv_idx, done, done_err
  );

  modport master (
    output req_valid, req_op, req_asid, req_vppn,
    output rd_e, rd_g, rd_asid, rd_vppn, rd_ps,
    input  req_ready, busy, rd_idx, inv_we, inv_idx, done, done_err
  );
endinterface

// File: rtl/tlb_inv_match.sv
// rtl/tlb_inv_match.sv - combinational INVTLB match predicate for one TLB entry
// Purpose: decides whether an entry is selected by an INVTLB op (E bit is gated by the caller).
// Ports:
//   in : op, asid, vppn          latched INVTLB operands
//   in : rd_g, rd_asid, rd_vppn, rd_ps   entry fields
//   out: match                   entry selected by op
module tlb_inv_match
  import tlb_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [9:0]  asid,
  input  logic [18:0] vppn,
  input  logic        rd_g,
  input  logic [9:0]  rd_asid,
  input  logic [18:0] rd_vppn,
  input  logic [5:0]  rd_ps,
  output logic        match
);

  logic vmatch;
  logic amatch;

  always_comb begin
    // A 4M page only compares the VPPN bits above its 4M boundary; any
    // other page size is treated as never matching an address-qualified op.
    vmatch = 1'b0;
    case (rd_ps)
      PS_4K:   vmatch = (rd_vppn == vppn);
      PS_4M:   vmatch = (rd_vppn[18:9] == vppn[18:9]);
      default: vmatch = 1'b0;
    endcase
    amatch = (rd_asid == asid);

    match = 1'b0;
    case (op)
      INV_ALL0, INV_ALL1: match = 1'b1;
      INV_G:              match = rd_g;
      INV_NG:             match = ~rd_g;
      INV_ASID:           match = ~rd_g & amatch;
      INV_ASID_VA:        match = ~rd_g & amatch & vmatch;
      INV_GASID_VA:       match = (rd_g | amatch) & vmatch;
      default:            match = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_inv_engine.sv
// rtl/tlb_inv_engine.sv - sequential INVTLB engine walking every TLB entry
// Purpose: accepts an INVTLB request, scans entries 0..TLBNUM-1 one per cycle and
//          clears E of each matching entry, then pulses done (done_err for illegal ops).
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  tlb_inv_engine_if.slave: request handshake, busy/done status,
//        entry read port (rd_*) and invalidate write port (inv_we/inv_idx)
module tlb_inv_engine
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  tlb_inv_engine_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

  inv_state_e       state;
  logic [IDX_W-1:0] idx;
  logic [4:0]       op_q;
  logic [9:0]       asid_q;
  logic [18:0]      vppn_q;
  logic             err;
  logic             req_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             done_err_q;
  logic             hit;

  tlb_inv_match u_match (
    .op      (op_q),
    .asid    (asid_q),
    .vppn    (vppn_q),
    .rd_g    (bus.rd_g),
    .rd_asid (bus.rd_asid),
    .rd_vppn (bus.rd_vppn),
    .rd_ps   (bus.rd_ps),
    .match   (hit)
  );

  // The write enable is combinational off the state register so that an
  // asynchronous reset removes it without waiting for a clock edge.
  assign bus.inv_we    = (state == ST_SCAN) & bus.rd_e & hit;
  assign bus.rd_idx    = idx;
  assign bus.inv_idx   = idx;
  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_err  = done_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      op_q        <= '0;
      asid_q      <= '0;
      vppn_q      <= '0;
      err         <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            asid_q      <= bus.req_asid;
            vppn_q      <= bus.req_vppn;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            idx         <= '0;
            if (bus.req_op <= INV_GASID_VA) begin
              state <= ST_SCAN;
            end else begin
              // Illegal op skips the walk entirely and reports straight away.
              state      <= ST_DONE;
              err        <= 1'b1;
              done_q     <= 1'b1;
              done_err_q <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          // idx wraps back to 0 after the last entry, leaving rd_idx at 0 in IDLE.
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state      <= ST_DONE;
            done_q     <= 1'b1;
            done_err_q <= err;
          end
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          err         <= 1'b0;
          done_q      <= 1'b0;
          done_err_q  <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          done_q      <= 1'b0;
          done_err_q  <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_inv_engine.sv
// tb/tb_tlb_inv_engine.sv - self-checking bench for tlb_inv_engine
module tb_tlb_inv_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlb_inv_engine_if #(.IDX_W(4)) bus();

  tlb_inv_engine #(.TLBNUM(16), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // TLB array model: E is owned by the clocked process, the rest by the stimulus.
  logic [15:0] e_arr = '0;
  logic [15:0] e_load = '0;
  logic        load_req = 1'b0;
  logic        g_arr    [16];
  logic [9:0]  asid_arr [16];
  logic [18:0] vppn_arr [16];
  logic [5:0]  ps_arr   [16];

  always @(posedge clk) begin
    if (load_req) e_arr <= e_load;
    else if (bus.inv_we) e_arr[bus.inv_idx] <= 1'b0;
  end

  assign bus.rd_e    = e_arr[bus.rd_idx];
  assign bus.rd_g    = g_arr[bus.rd_idx];
  assign bus.rd_asid = asid_arr[bus.rd_idx];
  assign bus.rd_vppn = vppn_arr[bus.rd_idx];
  assign bus.rd_ps   = ps_arr[bus.rd_idx];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: which entries an INVTLB should clear, from the op rules.
  function automatic logic [15:0] model(input int op, input int asid, input int vppn);
    logic [15:0] m = '0;
    for (int i = 0; i < 16; i++) begin
      bool_blk: begin
        int  ps = ps_arr[i];
        bit  same_asid = (asid_arr[i] == asid);
        bit  same_page;
        bit  sel;
        if (ps == 12)      same_page = (vppn_arr[i] == vppn);
        else if (ps == 22) same_page = ((vppn_arr[i] >> 9) == (vppn >> 9));
        else               same_page = 0;
        if (op == 0 || op == 1) sel = 1;
        else if (op == 2)       sel = g_arr[i];
        else if (op == 3)       sel = !g_arr[i];
        else if (op == 4)       sel = !g_arr[i] && same_asid;
        else if (op == 5)       sel = !g_arr[i] && same_asid && same_page;
        else if (op == 6)       sel = (g_arr[i] || same_asid) && same_page;
        else                    sel = 0;
        if (sel && e_arr[i]) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic load_e(input logic [15:0] v);
    @(negedge clk);
    e_load = v;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic set_entry(input int i, input logic g, input int a, input int v, input int ps);
    g_arr[i] = g;
    asid_arr[i] = 10'(a);
    vppn_arr[i] = 19'(v);
    ps_arr[i] = 6'(ps);
  endtask

  task automatic setup(input int id);
    logic [15:0] e = '0;
    for (int i = 0; i < 16; i++) set_entry(i, 1'b0, 5, 0, 12);
    case (id)
      0: begin
        for (int i = 0; i < 16; i++) set_entry(i, i[0], i, i, 12);
        e = 16'hFFFF;
      end
      1: begin
        set_entry(3, 1'b0, 5, 0, 12);
        set_entry(7, 1'b1, 5, 0, 12);
        set_entry(9, 1'b0, 6, 0, 12);
        e = 16'h0288;
      end
      2: begin
        for (int i = 0; i < 16; i++) set_entry(i, 1'b0, 1, 'h12345, 12);
        set_entry(4, 1'b0, 1, 'h12200, 22);
        set_entry(6, 1'b0, 1, 'h12344, 12);
        e = 16'h0054;
      end
      default: begin
        set_entry(1, 1'b1, 9, 'h00400, 12);
        set_entry(5, 1'b0, 3, 'h00400, 12);
        e = 16'h0022;
      end
    endcase
    load_e(e);
  endtask

  task automatic run_req(input string name, input int op, input int asid, input int vppn,
                         input logic [15:0] exp_m, input logic exp_err);
    logic [15:0] e_before = e_arr;
    logic [15:0] obs = '0;
    int writes = 0;
    int done_k = 0;
    logic err_seen = 1'b0;
    logic busy_seen = 1'b0;
    @(negedge clk);
    chk({name, ".ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op = 5'(op);
    bus.req_asid = 10'(asid);
    bus.req_vppn = 19'(vppn);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.inv_we) begin
        obs[bus.inv_idx] = 1'b1;
        writes++;
      end
      if (bus.done) begin
        done_k = k;
        err_seen = bus.done_err;
        busy_seen = bus.busy;
        break;
      end
    end
    chk({name, ".done_cycle"}, 32'(done_k), exp_err ? 32'd1 : 32'd17);
    chk({name, ".done_err"}, 32'(err_seen), 32'(exp_err));
    chk({name, ".busy_at_done"}, 32'(busy_seen), 32'd1);
    chk({name, ".inv_mask"}, 32'(obs), 32'(exp_m));
    chk({name, ".write_count"}, 32'(writes), 32'($countones(exp_m)));
    @(negedge clk);
    chk({name, ".ready_after"}, 32'(bus.req_ready), 32'd1);
    chk({name, ".done_pulse"}, 32'(bus.done), 32'd0);
    chk({name, ".e_final"}, 32'(e_arr), 32'(e_before & ~exp_m));
  endtask

  typedef struct {
    string       name;
    int          op;
    int          asid;
    int          vppn;
    int          setup_id;
    logic [15:0] exp_mask;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"op0_all",    0, 0,     0,         0, 16'hFFFF, 1'b0};
    vecs[1] = '{"op2_global", 2, 0,     0,         0, 16'hAAAA, 1'b0};
    vecs[2] = '{"op3_nonglb", 3, 0,     0,         0, 16'h5555, 1'b0};
    vecs[3] = '{"op4_asid",   4, 'h005, 0,         1, 16'h0008, 1'b0};
    vecs[4] = '{"op5_asidva", 5, 1,     'h12345,   2, 16'h0014, 1'b0};
    vecs[5] = '{"op6_gasid",  6, 2,     'h00400,   3, 16'h0002, 1'b0};
    vecs[6] = '{"op7_illeg",  7, 0,     0,         0, 16'h0000, 1'b1};
    vecs[7] = '{"op31_illeg", 31, 0,    0,         0, 16'h0000, 1'b1};

    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_asid = '0;
    bus.req_vppn = '0;
    for (int i = 0; i < 16; i++) set_entry(i, 1'b0, 0, 0, 12);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.done_err", 32'(bus.done_err), 32'd0);
    chk("rst.inv_we", 32'(bus.inv_we), 32'd0);
    chk("rst.rd_idx", 32'(bus.rd_idx), 32'd0);
    chk("rst.inv_idx", 32'(bus.inv_idx), 32'd0);
    rst = 1'b0;

    // Directed table
    for (int v = 0; v < 8; v++) begin
      setup(vecs[v].setup_id);
      run_req(vecs[v].name, vecs[v].op, vecs[v].asid, vecs[v].vppn,
              vecs[v].exp_mask, vecs[v].exp_err);
    end

    // Held request across two illegal ops: second accepted only after done
    begin
      logic [3:0] dn = '0;
      logic [3:0] rdy = '0;
      logic [3:0] we = '0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op = 5'd7;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        dn[k] = bus.done;
        rdy[k] = bus.req_ready;
        we[k] = bus.inv_we;
        if (k == 2) bus.req_valid = 1'b0;
      end
      chk("b2b.done_seq", 32'(dn), 32'b0101);
      chk("b2b.ready_seq", 32'(rdy), 32'b1010);
      chk("b2b.inv_we", 32'(we), 32'd0);
    end

    // Reset in the middle of an op=0 walk at idx 8
    begin
      int k = 0;
      setup(0);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op = 5'd0;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      for (k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (bus.rd_idx == 4'd8) break;
      end
      chk("mid.reach_idx8", 32'(k), 32'd9);
      chk("mid.we_before", 32'(bus.inv_we), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid.we_async", 32'(bus.inv_we), 32'd0);
      chk("mid.busy_async", 32'(bus.busy), 32'd0);
      repeat (2) begin
        @(negedge clk);
        chk("mid.no_done", 32'(bus.done), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("mid.ready_after", 32'(bus.req_ready), 32'd1);
      chk("mid.e_kept", 32'(e_arr), 32'hFF00);
    end

    // Randomized requests against the reference model
    for (int r = 0; r < 14; r++) begin
      int op;
      int asid;
      int vppn;
      logic [15:0] e;
      asid = $urandom_range(1, 3);
      vppn = $urandom_range(0, 19'h7FFFF);
      for (int i = 0; i < 16; i++) begin
        int ps_sel = $urandom_range(0, 4);
        int pv = ($urandom_range(0, 1) != 0) ? vppn : (vppn ^ (1 << $urandom_range(0, 18)));
        set_entry(i, 1'($urandom_range(0, 1)), $urandom_range(1, 3), pv,
                  (ps_sel < 2) ? 12 : (ps_sel < 4) ? 22 : $urandom_range(0, 63));
      end
      e = 16'($urandom);
      load_e(e);
      op = $urandom_range(0, 9);
      if (op > 7) op = $urandom_range(7, 31);
      run_req($sformatf("rand%0d_op%0d", r, op), op, asid, vppn,
              model(op, asid, vppn), op > 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
